// File: rtl/display_mode_controller.sv
// Display mode sequencer: one debounced key selects the 7-segment source
// (CLOCK -> SECONDS -> STOPWATCH), a long press toggles the display off, and
// idle SECONDS/STOPWATCH views fall back to CLOCK after TIMEOUT_SEC seconds.
module display_mode_controller #(
  parameter int unsigned LONG_PRESS_CYCLES = 25_000_000,
  parameter int unsigned TIMEOUT_SEC       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       tick_1hz,
  input  logic       sw_running,
  output logic [1:0] select,
  output logic       enable,
  output logic       mode_changed
);

  localparam int unsigned PW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned IW = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
  localparam logic [PW-1:0] PRESS_MAX  = PW'(LONG_PRESS_CYCLES);
  localparam logic [PW-1:0] PRESS_LAST = PW'(LONG_PRESS_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST  = (TIMEOUT_SEC > 0) ? IW'(TIMEOUT_SEC - 1) : '0;
  localparam logic          TO_ENABLED = (TIMEOUT_SEC > 0);

  typedef enum logic [1:0] {
    ST_CLOCK     = 2'b00,
    ST_SECONDS   = 2'b01,
    ST_STOPWATCH = 2'b10,
    ST_OFF       = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic          key_q, key_d;
  logic          long_done_q, long_done_d;
  logic [PW-1:0] press_cnt_q, press_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          enable_q, enable_d;
  logic          mode_changed_q, mode_changed_d;

  logic long_ev, short_ev, timeout_ev, counting;

  // Key tracking, event detection, next state and idle timer.
  always_comb begin
    armed_d        = armed_q | ~key_mode;
    key_d          = key_mode;
    press_cnt_d    = '0;
    long_done_d    = 1'b0;
    state_d        = state_q;
    idle_d         = idle_q;
    long_ev        = 1'b0;
    short_ev       = 1'b0;
    timeout_ev     = 1'b0;
    counting       = 1'b0;

    if (key_mode) begin
      press_cnt_d = (press_cnt_q == PRESS_MAX) ? press_cnt_q : press_cnt_q + 1'b1;
    end

    // Long fires on the edge where the held count reaches its limit, once per press.
    long_ev     = key_mode & armed_q & (press_cnt_q == PRESS_LAST);
    short_ev    = key_q & ~key_mode & ~long_done_q & armed_q;
    long_done_d = key_mode & (long_done_q | long_ev);

    counting   = (state_q == ST_SECONDS) | ((state_q == ST_STOPWATCH) & ~sw_running);
    timeout_ev = TO_ENABLED & tick_1hz & counting & ~key_mode & (idle_q == IDLE_LAST);

    if (long_ev) begin
      state_d = (state_q == ST_OFF) ? ST_CLOCK : ST_OFF;
    end else if (short_ev) begin
      unique case (state_q)
        ST_CLOCK:     state_d = ST_SECONDS;
        ST_SECONDS:   state_d = ST_STOPWATCH;
        ST_STOPWATCH: state_d = ST_CLOCK;
        ST_OFF:       state_d = ST_CLOCK;
        default:      state_d = ST_CLOCK;
      endcase
    end else if (timeout_ev) begin
      state_d = ST_CLOCK;
    end

    if ((state_d != state_q) || key_mode || !counting) begin
      idle_d = '0;
    end else if (tick_1hz && TO_ENABLED) begin
      idle_d = idle_q + 1'b1;
    end

    enable_d       = (state_d != ST_OFF);
    mode_changed_d = (state_d != state_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_CLOCK;
      armed_q        <= 1'b0;
      key_q          <= 1'b0;
      long_done_q    <= 1'b0;
      press_cnt_q    <= '0;
      idle_q         <= '0;
      enable_q       <= 1'b1;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      key_q          <= key_d;
      long_done_q    <= long_done_d;
      press_cnt_q    <= press_cnt_d;
      idle_q         <= idle_d;
      enable_q       <= enable_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign select       = state_q;
  assign enable       = enable_q;
  assign mode_changed = mode_changed_q;

endmodule
